if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Owns the PC and drives a req/ack instruction-memory port.
- Holds fetched instructions in IF/ID under decode stall; accepts a branch redirect from downstream.
- Presents the registered instruction, its PC+4, and the decoded OpCode/Funct fields to the control/decode stage.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and
// the instruction memory.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid
// buffer that catches a word returned while decode is stalled.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request outstanding at pc; IF/ID loads on ack unless stalled
// BUF   | fetched word parked in skid register; no request until drained
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic [5:0]        opcode,
    output logic [5:0]        funct
);

    typedef enum logic {FETCH, BUF} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic        ifid_valid_n;
    logic [31:0] ifid_instr_n;
    logic [31:0] ifid_pc4_n;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4 = pc + 32'd4;

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    assign opcode = ifid_instr[31:26];
    assign funct  = ifid_instr[5:0];

    // State, PC, skid buffer and IF/ID register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
            ifid_valid <= ifid_valid_n;
            ifid_instr <= ifid_instr_n;
            ifid_pc4   <= ifid_pc4_n;
        end
    end

    // Next-state logic; redirect outranks stall, ack and the skid buffer.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        ifid_valid_n = ifid_valid;
        ifid_instr_n = ifid_instr;
        ifid_pc4_n   = ifid_pc4;

        if (redirect) begin
            // Masking keeps all redirect_pc bits in use while dropping [1:0].
            pc_n         = redirect_pc & 32'hFFFF_FFFC;
            state_n      = FETCH;
            skid_instr_n = 32'h0;
            skid_pc4_n   = 32'h0;
            ifid_valid_n = 1'b0;
            ifid_instr_n = 32'h0;
            ifid_pc4_n   = 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        pc_n = pc_plus4;
                        if (stall) begin
                            skid_instr_n = imem.imem_rdata;
                            skid_pc4_n   = pc_plus4;
                            state_n      = BUF;
                        end else begin
                            ifid_valid_n = 1'b1;
                            ifid_instr_n = imem.imem_rdata;
                            ifid_pc4_n   = pc_plus4;
                        end
                    end else if (!stall) begin
                        ifid_valid_n = 1'b0;
                        ifid_instr_n = 32'h0;
                        ifid_pc4_n   = 32'h0;
                    end
                end
                BUF: begin
                    if (!stall) begin
                        ifid_valid_n = 1'b1;
                        ifid_instr_n = skid_instr;
                        ifid_pc4_n   = skid_pc4;
                        state_n      = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule
